sampletest_pipe: RTL
====================

// Module: sampletest_pipe
// PURPOSE
//  Next-generation sample test for the raster pipeline: multi-lane, elastic and mode-configurable.
//  Tests LANES samples against one triangle per beat using edge equations.
//  Supports back-face culling or two-sided acceptance, with valid/ready backpressure.
//  Pipelined at a fixed PIPE_DEPTH. Keeps a saturating hit counter for perf analysis.
//  Sits between the sample iterator (R16) and the shader/z-buffer interface (R18+).
// PARAMETERS
//  SIGFIG     24  bits per coordinate/colour word
//  RADIX      10  fraction bits (1.0 = 1024)
//  AXIS       3   axes per vertex (x,y,z)
//  COLORS     3   colour channels
//  LANES      4   samples tested per beat
//  EDGE_BITS  13  signed bits kept of each shifted coordinate before multiply
//  PIPE_DEPTH 3   latency in cycles from accept to out_valid (fixed at 3)
//  CNT_W      32  hit counter width
// PORTS
//  clk             in   1                       clock, rising edge
//  rst             in   1                       asynchronous, active-low reset
//  in_valid_R16H   in   1                       beat present on inputs
//  in_ready_R16H   out  1                       block accepts beat this cycle
//  tri_R16S        in   SIGFIG x 3 x AXIS       triangle vertices, signed
//  color_R16U      in   SIGFIG x COLORS         triangle colour
//  sample_R16S     in   SIGFIG x LANES x 2      per-lane sample (x,y)
//  validSamp_R16H  in   LANES                   per-lane sample enable
//  cull_mode       in   1                       0 = back-face cull, 1 = two-sided
//  cnt_clr         in   1                       synchronous clear of hit_count
//  out_valid_R18H  out  1                       result beat present
//  out_ready_R18H  in   1                       downstream accepts result
//  hit_R18S        out  SIGFIG x LANES x AXIS   per lane {sample x, sample y, v0.z}
//  color_R18U      out  SIGFIG x COLORS         colour passed through
//  hit_valid_R18H  out  LANES                   per-lane hit flag
//  hit_count       out  CNT_W                   saturating count of hits delivered
// BEHAVIOUR
//  - Reset (rst low, async): all stage valids, out_valid, hit_valid, hit_R18S, color_R18U and hit_count are 0.
//  - Global advance: adv = !out_valid_R18H || out_ready_R18H. in_ready_R16H = adv.
//  - A beat is accepted when in_valid & in_ready. All stages shift only when adv is high.
//  - Stall (adv low): every stage and every output holds bit-stable, and no beats are lost.
//  - Zero-stall latency is exactly 3 cycles, with throughput of 1 beat per cycle.
//  - Bubbles propagate as invalid stages. They are never emitted.
//  - Stage 1 (per lane): shift = tri[v][a] - sample[a] for v in 0..2, a in {x,y}.
//    The result is truncated to the low EDGE_BITS bits, interpreted as signed.
//  - Stage 2: registers the six products. Each product is 2*EDGE_BITS bits signed.
//  - Stage 3: d0 = x0*y1 - x1*y0, d1 = x1*y2 - x2*y1, d2 = x2*y0 - x0*y2.
//    Each d is 2*EDGE_BITS+1 bits signed, with no overflow.
//  - Hit test, back-face (mode 0): hit = d0<=0 & d1<0 & d2<=0.
//  - Hit test, two-sided (mode 1): the mode-0 test OR (d0>=0 & d1>0 & d2>=0).
//  - d1 == 0 always rejects, including for degenerate triangles.
//  - hit_valid lane = validSamp lane & hit.
//  - cull_mode is sampled with the beat at accept and travels with it.
//  - hit_R18S carries the unjittered sample_R16S; z is tri[0].z.
//  - hit_count: on each out_valid & out_ready, adds popcount(hit_valid_R18H). It saturates at 2^CNT_W-1.
//  - cnt_clr has priority: when asserted, the count becomes 0 that cycle.
//  - Reset asserted mid-flight drops all in-flight beats. After release, in_ready = 1 on the first cycle.
// TESTING
//  - Hit, mode 0: tri v0=(0,1024), v1=(1024,-1024), v2=(-1024,-1024); sample (0,0) in all lanes, all valid.
//    Expect hit_valid=4'b1111 at cycle 3 and hit_count=4.
//  - Cull: swap v1/v2 from the previous test. Mode 0 gives hit_valid=0000; mode 1 gives 1111.
//  - Edge rule: lane0 sample (0,-1024) on edge v1-v2 (d1=0) -> lane0=0.
//    lane1 sample on edge v0-v1 with d0=0, d1<0 -> lane1=1. Lanes with validSamp=0 -> 0.
//  - Backpressure: 6 back-to-back beats with out_ready low for cycles 4-7. All 6 beats are delivered in order,
//    with outputs stable while stalled and in_ready=0 while out_valid & !out_ready.
//  - Counter: preload near saturation (CNT_W=4, 14 hits) then deliver 4 more hits -> count=15.
//    cnt_clr on the same cycle as a hit -> count=0.
//  - Reset: assert rst low with 3 beats in flight -> out_valid=0 immediately.
//    No stale beats appear after release.

Source files
------------

// File: rtl/sampletest_pipe.sv
// sampletest_pipe
// Multi-lane edge-equation sample test with three register stages and a
// single global advance.
//   Stage 1: each lane registers its vertex-minus-sample offsets.
//   Stage 2: the six cross products are registered.
//   Stage 3: determinants, hit test and result beat are registered.
// A saturating counter totals the hits handed downstream.
module sampletest_pipe #(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int LANES      = 4,
    parameter int EDGE_BITS  = 13,
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid_R16H,
    output logic                                   in_ready_R16H,
    input  logic [2:0][AXIS-1:0][SIGFIG-1:0]       tri_R16S,
    input  logic [COLORS-1:0][SIGFIG-1:0]          color_R16U,
    input  logic [LANES-1:0][1:0][SIGFIG-1:0]      sample_R16S,
    input  logic [LANES-1:0]                       validSamp_R16H,
    input  logic                                   cull_mode,
    input  logic                                   cnt_clr,
    output logic                                   out_valid_R18H,
    input  logic                                   out_ready_R18H,
    output logic [LANES-1:0][AXIS-1:0][SIGFIG-1:0] hit_R18S,
    output logic [COLORS-1:0][SIGFIG-1:0]          color_R18U,
    output logic [LANES-1:0]                       hit_valid_R18H,
    output logic [CNT_W-1:0]                       hit_count
);

    localparam int EW = EDGE_BITS;
    localparam int PW = 2 * EDGE_BITS;
    localparam int DW = 2 * EDGE_BITS + 1;

    typedef logic signed [EW-1:0] edge_t;
    typedef logic signed [PW-1:0] prod_t;
    typedef logic signed [DW-1:0] det_t;

    // The data path below is built for exactly three stages and x/y/z vertices.
    generate
        if (PIPE_DEPTH != 3 || AXIS < 3 || RADIX >= SIGFIG) begin : g_bad_params
            $error("sampletest_pipe: unsupported parameter combination");
        end
    endgenerate

    // Signed product of two truncated edge offsets, kept at full width.
    function automatic prod_t mul_edge(input edge_t a, input edge_t b);
        return PW'(a) * PW'(b);
    endfunction

    logic adv;

    logic [PIPE_DEPTH-1:0] vld_d, vld_q;

    edge_t                             s1_sh_d [LANES][3][2];
    edge_t                             s1_sh_q [LANES][3][2];
    logic [LANES-1:0][1:0][SIGFIG-1:0] s1_samp_d, s1_samp_q;
    logic [LANES-1:0]                  s1_vs_d, s1_vs_q;
    logic                              s1_mode_d, s1_mode_q;
    logic [COLORS-1:0][SIGFIG-1:0]     s1_color_d, s1_color_q;
    logic [SIGFIG-1:0]                 s1_z_d, s1_z_q;

    prod_t                             s2_prod_d [LANES][6];
    prod_t                             s2_prod_q [LANES][6];
    logic [LANES-1:0][1:0][SIGFIG-1:0] s2_samp_d, s2_samp_q;
    logic [LANES-1:0]                  s2_vs_d, s2_vs_q;
    logic                              s2_mode_d, s2_mode_q;
    logic [COLORS-1:0][SIGFIG-1:0]     s2_color_d, s2_color_q;
    logic [SIGFIG-1:0]                 s2_z_d, s2_z_q;

    det_t                              det [LANES][3];
    logic [LANES-1:0]                  lane_hit;

    logic [LANES-1:0][AXIS-1:0][SIGFIG-1:0] hit_d, hit_q;
    logic [COLORS-1:0][SIGFIG-1:0]          color_out_d, color_out_q;
    logic [LANES-1:0]                       hit_valid_d, hit_valid_q;
    logic [CNT_W-1:0]                       hit_count_d, hit_count_q;
    logic [CNT_W:0]                         hit_pop;
    logic [CNT_W:0]                         hit_sum;

    // The upper coordinate bits and the z of v1/v2 play no part in the test.
    logic unused_tri_bits;
    assign unused_tri_bits = ^tri_R16S;

    // One advance signal moves every stage; a held result freezes the whole pipe.
    assign adv            = !vld_q[PIPE_DEPTH-1] || out_ready_R18H;
    assign in_ready_R16H  = adv;
    assign out_valid_R18H = vld_q[PIPE_DEPTH-1];
    assign hit_R18S       = hit_q;
    assign color_R18U     = color_out_q;
    assign hit_valid_R18H = hit_valid_q;
    assign hit_count      = hit_count_q;

    // Valid chain: a beat enters when accepted, bubbles shift through as zeros.
    always_comb begin
        vld_d = vld_q;
        if (adv) begin
            vld_d = {vld_q[PIPE_DEPTH-2:0], in_valid_R16H};
        end
    end

    // Stage 1: vertex minus sample per lane, wrapped to EDGE_BITS signed bits.
    always_comb begin
        s1_sh_d    = s1_sh_q;
        s1_samp_d  = s1_samp_q;
        s1_vs_d    = s1_vs_q;
        s1_mode_d  = s1_mode_q;
        s1_color_d = s1_color_q;
        s1_z_d     = s1_z_q;
        if (adv) begin
            for (int l = 0; l < LANES; l++) begin
                for (int v = 0; v < 3; v++) begin
                    for (int a = 0; a < 2; a++) begin
                        s1_sh_d[l][v][a] = $signed(tri_R16S[v][a][EW-1:0]
                                                   - sample_R16S[l][a][EW-1:0]);
                    end
                end
            end
            s1_samp_d  = sample_R16S;
            s1_vs_d    = validSamp_R16H;
            s1_mode_d  = cull_mode;
            s1_color_d = color_R16U;
            s1_z_d     = tri_R16S[0][2];
        end
    end

    // Stage 2: the six cross products x0y1, x1y0, x1y2, x2y1, x2y0, x0y2.
    always_comb begin
        s2_prod_d  = s2_prod_q;
        s2_samp_d  = s2_samp_q;
        s2_vs_d    = s2_vs_q;
        s2_mode_d  = s2_mode_q;
        s2_color_d = s2_color_q;
        s2_z_d     = s2_z_q;
        if (adv) begin
            for (int l = 0; l < LANES; l++) begin
                s2_prod_d[l][0] = mul_edge(s1_sh_q[l][0][0], s1_sh_q[l][1][1]);
                s2_prod_d[l][1] = mul_edge(s1_sh_q[l][1][0], s1_sh_q[l][0][1]);
                s2_prod_d[l][2] = mul_edge(s1_sh_q[l][1][0], s1_sh_q[l][2][1]);
                s2_prod_d[l][3] = mul_edge(s1_sh_q[l][2][0], s1_sh_q[l][1][1]);
                s2_prod_d[l][4] = mul_edge(s1_sh_q[l][2][0], s1_sh_q[l][0][1]);
                s2_prod_d[l][5] = mul_edge(s1_sh_q[l][0][0], s1_sh_q[l][2][1]);
            end
            s2_samp_d  = s1_samp_q;
            s2_vs_d    = s1_vs_q;
            s2_mode_d  = s1_mode_q;
            s2_color_d = s1_color_q;
            s2_z_d     = s1_z_q;
        end
    end

    // Stage 3 decision: d1 must be strictly signed so zero-area and on-edge-1 reject.
    always_comb begin
        lane_hit = '0;
        for (int l = 0; l < LANES; l++) begin
            logic neg_side;
            logic pos_side;
            det[l][0] = DW'(s2_prod_q[l][0]) - DW'(s2_prod_q[l][1]);
            det[l][1] = DW'(s2_prod_q[l][2]) - DW'(s2_prod_q[l][3]);
            det[l][2] = DW'(s2_prod_q[l][4]) - DW'(s2_prod_q[l][5]);
            neg_side  = (det[l][0][DW-1] || (det[l][0] == '0))
                     && det[l][1][DW-1]
                     && (det[l][2][DW-1] || (det[l][2] == '0));
            pos_side  = !det[l][0][DW-1]
                     && !det[l][1][DW-1] && (det[l][1] != '0)
                     && !det[l][2][DW-1];
            lane_hit[l] = neg_side || (s2_mode_q && pos_side);
        end
    end

    // Result register: the sample is returned unjittered with v0.z as depth.
    always_comb begin
        hit_d       = hit_q;
        color_out_d = color_out_q;
        hit_valid_d = hit_valid_q;
        if (adv) begin
            hit_d = '0;
            for (int l = 0; l < LANES; l++) begin
                hit_d[l][0] = s2_samp_q[l][0];
                hit_d[l][1] = s2_samp_q[l][1];
                hit_d[l][2] = s2_z_q;
            end
            color_out_d = s2_color_q;
            hit_valid_d = s2_vs_q & lane_hit & {LANES{vld_q[PIPE_DEPTH-2]}};
        end
    end

    // Hit counter: adds delivered hits, pins at all-ones, clear wins over update.
    always_comb begin
        hit_pop = '0;
        for (int l = 0; l < LANES; l++) begin
            hit_pop = hit_pop + (CNT_W+1)'(hit_valid_q[l]);
        end
        hit_sum     = {1'b0, hit_count_q} + hit_pop;
        hit_count_d = hit_count_q;
        if (cnt_clr) begin
            hit_count_d = '0;
        end else if (vld_q[PIPE_DEPTH-1] && out_ready_R18H) begin
            hit_count_d = hit_sum[CNT_W] ? '1 : hit_sum[CNT_W-1:0];
        end
    end

    // All state registers; reset empties the pipe and clears the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q       <= '0;
            s1_sh_q     <= '{default: '0};
            s1_samp_q   <= '0;
            s1_vs_q     <= '0;
            s1_mode_q   <= 1'b0;
            s1_color_q  <= '0;
            s1_z_q      <= '0;
            s2_prod_q   <= '{default: '0};
            s2_samp_q   <= '0;
            s2_vs_q     <= '0;
            s2_mode_q   <= 1'b0;
            s2_color_q  <= '0;
            s2_z_q      <= '0;
            hit_q       <= '0;
            color_out_q <= '0;
            hit_valid_q <= '0;
            hit_count_q <= '0;
        end else begin
            vld_q       <= vld_d;
            s1_sh_q     <= s1_sh_d;
            s1_samp_q   <= s1_samp_d;
            s1_vs_q     <= s1_vs_d;
            s1_mode_q   <= s1_mode_d;
            s1_color_q  <= s1_color_d;
            s1_z_q      <= s1_z_d;
            s2_prod_q   <= s2_prod_d;
            s2_samp_q   <= s2_samp_d;
            s2_vs_q     <= s2_vs_d;
            s2_mode_q   <= s2_mode_d;
            s2_color_q  <= s2_color_d;
            s2_z_q      <= s2_z_d;
            hit_q       <= hit_d;
            color_out_q <= color_out_d;
            hit_valid_q <= hit_valid_d;
            hit_count_q <= hit_count_d;
        end
    end

endmodule
